// File: rtl/fpga_core_pkg.sv
// Shared constants, configuration field offsets and source-index map for the fpga_core fabric.
package fpga_core_pkg;

  localparam int unsigned N_TILES   = 64;
  localparam int unsigned TILE_BITS = 69;
  localparam int unsigned DW        = 32;
  localparam int unsigned CFG_BITS  = N_TILES * TILE_BITS;

  localparam int unsigned REG_SEL     = 68;
  localparam int unsigned LUT_LSB     = 52;
  localparam int unsigned SEL_LSB     = 20;
  localparam int unsigned ROUTE_A_LSB = 0;
  localparam int unsigned ROUTE_B_LSB = 10;

  localparam int unsigned SRC_IN   = 0;
  localparam int unsigned SRC_TILE = 128;
  localparam int unsigned SRC_ZERO = 192;
  localparam int unsigned SRC_W    = 256;

  typedef struct packed {
    logic       en;
    logic       inv;
    logic [7:0] src;
  } route_t;

  function automatic logic route_bit(route_t r, logic [SRC_W-1:0] src);
    return r.en & (src[r.src] ^ r.inv);
  endfunction

endpackage

// File: rtl/fpga_tile.sv
// One fabric tile: four source selects feeding a 4-input LUT with an optional output flop.
module fpga_tile
  import fpga_core_pkg::*;
(
  input  logic                        clb_clk,
  input  logic                        rst_n,
  input  logic                        prog_en,
  input  logic [TILE_BITS-1:SEL_LSB]  cfg,
  input  logic [SRC_W-1:0]            src,
  output logic                        tile_out
);

  logic [3:0]  x;
  logic [15:0] truth;
  logic        lut;
  logic        q;

  always_comb begin
    x = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      x[k] = src[cfg[SEL_LSB + 8*k +: 8]];
    end
  end

  assign truth = cfg[LUT_LSB +: 16];
  assign lut   = truth[x];

  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (!prog_en) begin
      q <= lut;
    end
  end

  // Forcing tile outputs low while programming breaks any transient loops a
  // half-loaded bitstream can form; user outputs are forced low then anyway.
  assign tile_out = prog_en ? 1'b0 : (cfg[REG_SEL] ? q : lut);

endmodule

// File: rtl/fpga_core.sv
// Programmable fabric core: serial configuration chain, 64 LUT tiles and 128 output route muxes.
module fpga_core
  import fpga_core_pkg::*;
(
  input  logic          clb_clk,
  input  logic          rst_n,
  input  logic          prog_en,
  input  logic          prog_in,
  output logic          prog_out,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  input  logic [DW-1:0] in4,
  output logic [DW-1:0] out1,
  output logic [DW-1:0] out2,
  output logic [DW-1:0] out3,
  output logic [DW-1:0] out4
);

  logic [CFG_BITS-1:0]  cfg;
  logic [SRC_W-1:0]     src_vec;
  logic [N_TILES-1:0]   tile_out;
  logic [2*N_TILES-1:0] o_vec;

  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (prog_en) begin
      cfg <= {prog_in, cfg[CFG_BITS-1:1]};
    end
  end

  assign prog_out = cfg[0];

  assign src_vec[SRC_IN +: 4*DW]             = {in4, in3, in2, in1};
  assign src_vec[SRC_TILE +: N_TILES]        = tile_out;
  assign src_vec[SRC_W-1:SRC_ZERO]           = '0;

  for (genvar t = 0; t < N_TILES; t++) begin : g_tile
    fpga_tile u_tile (
      .clb_clk  (clb_clk),
      .rst_n    (rst_n),
      .prog_en  (prog_en),
      .cfg      (cfg[TILE_BITS*t + SEL_LSB +: TILE_BITS-SEL_LSB]),
      .src      (src_vec),
      .tile_out (tile_out[t])
    );

    assign o_vec[2*t]   = route_bit(route_t'(cfg[TILE_BITS*t + ROUTE_A_LSB +: 10]), src_vec);
    assign o_vec[2*t+1] = route_bit(route_t'(cfg[TILE_BITS*t + ROUTE_B_LSB +: 10]), src_vec);
  end

  assign {out4, out3, out2, out1} = prog_en ? '0 : o_vec;

endmodule

// File: tb/tb_fpga_core.sv
// Self-checking bench for fpga_core against a bit-level behavioural model of the fabric.
module tb_fpga_core;
  import fpga_core_pkg::*;

  logic        clb_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        prog_en = 1'b0;
  logic        prog_in = 1'b0;
  logic        prog_out;
  logic [31:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic [31:0] out1, out2, out3, out4;

  always #5 clb_clk = ~clb_clk;

  fpga_core dut (
    .clb_clk  (clb_clk),
    .rst_n    (rst_n),
    .prog_en  (prog_en),
    .prog_in  (prog_in),
    .prog_out (prog_out),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  logic [CFG_BITS-1:0] m_cfg  = '0;
  logic [63:0]         m_flop = '0;
  logic [CFG_BITS-1:0] bs;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic src_of(input int unsigned idx, input logic [127:0] sin, input logic [63:0] tv);
    if (idx < 128) return sin[idx];
    if (idx < 192) return tv[idx-128];
    return 1'b0;
  endfunction

  function automatic logic lut_of(input int t, input logic [127:0] sin, input logic [63:0] tv);
    logic [68:0] f;
    logic [3:0]  a;
    f = m_cfg[69*t +: 69];
    for (int k = 0; k < 4; k++) a[k] = src_of(int'(f[20 + 8*k +: 8]), sin, tv);
    return f[52 + int'(a)];
  endfunction

  // Combinational tiles are settled by relaxation until nothing changes.
  function automatic logic [63:0] tiles_of(input logic [127:0] sin);
    logic [63:0] tv, prev;
    for (int t = 0; t < 64; t++) tv[t] = m_cfg[69*t + 68] ? m_flop[t] : 1'b0;
    for (int it = 0; it <= 64; it++) begin
      prev = tv;
      for (int t = 0; t < 64; t++)
        if (!m_cfg[69*t + 68]) tv[t] = lut_of(t, sin, tv);
      if (tv == prev) break;
    end
    return tv;
  endfunction

  function automatic logic [127:0] model_o();
    logic [127:0] sin, o;
    logic [63:0]  tv;
    logic [9:0]   r;
    o = '0;
    if (prog_en) return o;
    sin = {in4, in3, in2, in1};
    tv  = tiles_of(sin);
    for (int b = 0; b < 128; b++) begin
      r    = m_cfg[69*(b/2) + ((b % 2) ? 10 : 0) +: 10];
      o[b] = r[9] & (src_of(int'(r[7:0]), sin, tv) ^ r[8]);
    end
    return o;
  endfunction

  always @(posedge clb_clk or negedge rst_n) begin
    logic [127:0] sin;
    logic [63:0]  tv, nxt;
    if (!rst_n) begin
      m_cfg  = '0;
      m_flop = '0;
    end else if (prog_en) begin
      m_cfg = {prog_in, m_cfg[CFG_BITS-1:1]};
    end else begin
      sin = {in4, in3, in2, in1};
      tv  = tiles_of(sin);
      for (int t = 0; t < 64; t++) nxt[t] = lut_of(t, sin, tv);
      m_flop = nxt;
    end
  end

  always @(negedge clb_clk) begin
    if (cmp_on) begin
      check("outputs", {out4, out3, out2, out1}, model_o());
      check("prog_out", 128'(prog_out), 128'(m_cfg[0]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clb_clk);
    @(negedge clb_clk);
    #1;
  endtask

  task automatic rand_in();
    in1 = $urandom; in2 = $urandom; in3 = $urandom; in4 = $urandom;
  endtask

  task automatic put_tile(input int t, input logic rs, input logic [15:0] tt,
                          input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                          input logic [7:0] s3, input logic [9:0] ra, input logic [9:0] rb);
    bs[69*t +: 69] = {rs, tt, s3, s2, s1, s0, rb, ra};
  endtask

  task automatic shift_bs();
    prog_en = 1'b1;
    for (int i = 0; i < CFG_BITS; i++) begin
      prog_in = bs[i];
      tick();
    end
    prog_en = 1'b0;
    prog_in = 1'b0;
  endtask

  task automatic build_passthrough(input logic inv);
    bs = '0;
    for (int t = 0; t < 64; t++)
      put_tile(t, 1'b0, 16'h0, 8'd0, 8'd0, 8'd0, 8'd0,
               {1'b1, inv, 8'(2*t)}, {1'b1, inv, 8'(2*t+1)});
  endtask

  function automatic logic [7:0] pick_src(input int t, input logic rs);
    int unsigned kind;
    kind = $urandom_range(0, 3);
    if (kind <= 1) return 8'($urandom_range(0, 127));
    if (kind == 3) return 8'($urandom_range(192, 255));
    if (rs) return 8'($urandom_range(128, 191));
    if (t > 0) return 8'(128 + $urandom_range(0, t-1));
    return 8'($urandom_range(0, 127));
  endfunction

  // Combinational tiles only read lower-numbered tiles, so no illegal loops arise.
  task automatic build_random();
    logic rs;
    bs = '0;
    for (int t = 0; t < 64; t++) begin
      rs = 1'($urandom);
      put_tile(t, rs, 16'($urandom), pick_src(t, rs), pick_src(t, rs), pick_src(t, rs),
               pick_src(t, rs), 10'($urandom), 10'($urandom));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ones;

    in1 = 32'h12153524; in2 = 32'hC0895E81; in3 = 32'h8484D609; in4 = 32'hB1F05663;
    repeat (2) tick();
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    tick();
    check("reset_outputs", {out4, out3, out2, out1}, 128'h0);
    check("reset_prog_out", 128'(prog_out), 128'h0);

    bs = '0;
    shift_bs();
    repeat (20) begin rand_in(); tick(); end
    check("zero_bs_outputs", {out4, out3, out2, out1}, 128'h0);

    build_passthrough(1'b0);
    shift_bs();
    in1 = 32'hDEADBEEF; in2 = 32'h01234567; in3 = 32'hFFFFFFFF; in4 = 32'h0;
    #1;
    check("passthrough", {out4, out3, out2, out1}, 128'h00000000_FFFFFFFF_01234567_DEADBEEF);
    tick();
    repeat (10) begin rand_in(); tick(); end

    build_passthrough(1'b1);
    shift_bs();
    in1 = 32'hDEADBEEF; in2 = 32'h01234567; in3 = 32'hFFFFFFFF; in4 = 32'h0;
    #1;
    check("passthrough_inv", {out4, out3, out2, out1}, 128'hFFFFFFFF_00000000_FEDCBA98_21524110);
    tick();

    bs = '0;
    put_tile(0, 1'b1, 16'h8000, 8'd0, 8'd1, 8'd2, 8'd3, {1'b1, 1'b0, 8'd128}, 10'h0);
    shift_bs();
    in1 = 32'h0; in2 = '0; in3 = '0; in4 = '0;
    tick();
    in1 = 32'h0000000F;
    #1;
    check("and_before_edge", 128'(out1[0]), 128'h0);
    tick();
    check("and_rise", 128'(out1[0]), 128'h1);
    in1 = 32'h00000007;
    #1;
    check("and_hold_until_edge", 128'(out1[0]), 128'h1);
    tick();
    check("and_fall", 128'(out1[0]), 128'h0);

    repeat (2) begin
      build_random();
      shift_bs();
      repeat (100) begin rand_in(); tick(); end
    end

    prog_en = 1'b1;
    prog_in = 1'b1;
    repeat (CFG_BITS) tick();
    check("chain_outputs_forced", {out4, out3, out2, out1}, 128'h0);
    prog_in = 1'b0;
    ones = 0;
    for (int i = 0; i < CFG_BITS + 8; i++) begin
      if (prog_out === 1'b1) ones++;
      tick();
    end
    check("chain_ones", 128'(ones), 128'(CFG_BITS));
    check("chain_drained", 128'(prog_out), 128'h0);
    prog_en = 1'b0;
    tick();

    build_passthrough(1'b0);
    prog_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      prog_in = bs[i];
      tick();
    end
    rst_n   = 1'b0;
    prog_en = 1'b0;
    prog_in = 1'b0;
    #1;
    check("midprog_reset_prog_out", 128'(prog_out), 128'h0);
    tick();
    rst_n = 1'b1;
    in1 = '1; in2 = '1; in3 = '1; in4 = '1;
    tick();
    check("midprog_cfg_cleared", {out4, out3, out2, out1}, 128'h0);
    shift_bs();
    in1 = 32'hDEADBEEF; in2 = 32'h01234567; in3 = 32'hFFFFFFFF; in4 = 32'h0;
    #1;
    check("reload_passthrough", {out4, out3, out2, out1}, 128'h00000000_FFFFFFFF_01234567_DEADBEEF);
    repeat (10) begin tick(); rand_in(); end
    tick();

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
